// File: rtl/itcm_ram_pkg.sv
// Shared geometry and types for the 8K x 64 instruction-TCM RAM.
package itcm_ram_pkg;

    localparam int ITCM_DP = 8192;
    localparam int ITCM_DW = 64;
    localparam int ITCM_MW = 8;
    localparam int ITCM_AW = 13;

    typedef logic [ITCM_AW-1:0] itcm_addr_t;
    typedef logic [ITCM_DW-1:0] itcm_data_t;
    typedef logic [ITCM_MW-1:0] itcm_wem_t;

endpackage

// File: rtl/itcm_ram_8kx64_if.sv
// RAM access port: power pins, chip select, write strobe, address, byte mask and data.
// valid/ready: there is no backpressure; cs=1 at a rising edge is one accepted access.
interface itcm_ram_8kx64_if;
    import itcm_ram_pkg::*;

    logic       sd;
    logic       ds;
    logic       ls;
    logic       cs;
    logic       we;
    itcm_addr_t addr;
    itcm_wem_t  wem;
    itcm_data_t din;
    itcm_data_t dout;

    modport master (output sd, ds, ls, cs, we, addr, wem, din, input dout);
    modport slave  (input sd, ds, ls, cs, we, addr, wem, din, output dout);
endinterface

// File: rtl/itcm_ram_core.sv
// Generic single-port RAM with a byte write mask, a registered read address and
// an optional output stage that presents unknown bits as 0.
module itcm_ram_core #(
    parameter int DP           = 8192,
    parameter int DW           = 64,
    parameter int MW           = 8,
    parameter int AW           = 13,
    parameter int FORCE_X2ZERO = 1
) (
    input  logic          clk,
    input  logic          i_clr,
    input  logic          i_cs,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [MW-1:0] i_wem,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_dout,
    output logic [AW-1:0] o_addr_q
);
    localparam int LW = DW / MW;

    logic [DW-1:0] r_mem [DP];
    logic [AW-1:0] r_addr;
    logic [DW-1:0] w_rdata;

    always_ff @(posedge clk) begin
        if (i_cs && i_we) begin
            for (int i = 0; i < MW; i++) begin
                if (i_wem[i]) r_mem[i_addr][i*LW +: LW] <= i_din[i*LW +: LW];
            end
        end
    end

    // Clear wins over a simultaneous read; writes never move the read address.
    always_ff @(posedge clk) begin
        if (i_clr)              r_addr <= '0;
        else if (i_cs && !i_we) r_addr <= i_addr;
    end

    assign w_rdata  = r_mem[r_addr];
    assign o_addr_q = r_addr;

    generate
        if (FORCE_X2ZERO != 0) begin : g_x2zero
            for (genvar b = 0; b < DW; b++) begin : g_bit
                assign o_dout[b] = (w_rdata[b] === 1'b1);
            end
        end else begin : g_raw
            assign o_dout = w_rdata;
        end
    endgenerate
endmodule

// File: rtl/itcm_ram_8kx64.sv
// E203 ITCM RAM, 8192 x 64, byte-masked, 1-cycle read latency. Optional power-pin
// handling is compiled in with ITCM_RAM_PWR_CTRL_EN; by default sd/ds/ls are ignored.
import itcm_ram_pkg::*;

module itcm_ram_8kx64 #(
    parameter int FORCE_X2ZERO = 1
) (
    input logic               clk,
    input logic               rst_n,
    itcm_ram_8kx64_if.slave   bus
);
    logic       w_cs;
    itcm_data_t w_core_dout;
    itcm_addr_t w_addr_q;

    itcm_ram_core #(
        .DP          (ITCM_DP),
        .DW          (ITCM_DW),
        .MW          (ITCM_MW),
        .AW          (ITCM_AW),
        .FORCE_X2ZERO(FORCE_X2ZERO)
    ) u_core (
        .clk     (clk),
        .i_clr   (rst_n),
        .i_cs    (w_cs),
        .i_we    (bus.we),
        .i_addr  (bus.addr),
        .i_wem   (bus.wem),
        .i_din   (bus.din),
        .o_dout  (w_core_dout),
        .o_addr_q(w_addr_q)
    );

`ifdef ITCM_RAM_PWR_CTRL_EN
    localparam int LW = ITCM_DW / ITCM_MW;

    // Per-byte validity stands in for contents lost during shutdown.
    logic [ITCM_MW-1:0] r_bvalid [ITCM_DP];
    itcm_data_t         w_dout;

    assign w_cs = bus.cs & ~bus.sd & ~bus.ds & ~bus.ls;

    always_ff @(posedge clk) begin
        if (bus.sd) begin
            for (int k = 0; k < ITCM_DP; k++) r_bvalid[k] <= '0;
        end else if (w_cs && bus.we) begin
            r_bvalid[bus.addr] <= r_bvalid[bus.addr] | bus.wem;
        end
    end

    always_comb begin
        w_dout = '0;
        if (!bus.sd) begin
            for (int i = 0; i < ITCM_MW; i++) begin
                if (r_bvalid[w_addr_q][i] === 1'b1) w_dout[i*LW +: LW] = w_core_dout[i*LW +: LW];
            end
        end
    end

    assign bus.dout = w_dout;
`else
    logic w_unused_pwr;

    assign w_cs         = bus.cs;
    assign w_unused_pwr = ^{bus.sd, bus.ds, bus.ls, w_addr_q};
    assign bus.dout     = w_core_dout;
`endif
endmodule

// File: tb/tb_itcm_ram_8kx64.sv
// Self-checking bench for itcm_ram_8kx64: directed test-plan sequences plus a
// randomized run against a behavioural memory model feeding an expected queue.
module tb_itcm_ram_8kx64;
    logic clk;
    logic rst_n;

    itcm_ram_8kx64_if bus ();

    itcm_ram_8kx64 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [63:0] exp_q [$];
    logic [63:0] mem_m [8192];
    logic [12:0] m_addr;
    int          n_checks;
    int          n_errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle, advance the model on the edge, then compare #1 later.
    task automatic step(input string tag, input logic rst, input logic cs, input logic we,
                        input logic [12:0] a, input logic [7:0] m, input logic [63:0] d,
                        input logic [2:0] pwr);
        @(negedge clk);
        rst_n    = rst;
        bus.cs   = cs;
        bus.we   = we;
        bus.addr = a;
        bus.wem  = m;
        bus.din  = d;
        {bus.sd, bus.ds, bus.ls} = pwr;
        @(posedge clk);
        if (cs && we) begin
            for (int i = 0; i < 8; i++) begin
                if (m[i]) mem_m[a][i*8 +: 8] = d[i*8 +: 8];
            end
        end
        if (rst)              m_addr = '0;
        else if (cs && !we)   m_addr = a;
        exp_q.push_back(mem_m[m_addr]);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: expected queue empty", tag);
        end else begin
            check_eq(tag, bus.dout, exp_q.pop_front());
        end
    endtask

    task automatic wr(input string tag, input logic [12:0] a, input logic [7:0] m, input logic [63:0] d);
        step(tag, 1'b0, 1'b1, 1'b1, a, m, d, 3'b000);
    endtask

    task automatic rd(input string tag, input logic [12:0] a);
        step(tag, 1'b0, 1'b1, 1'b0, a, 8'h00, 64'h0, 3'b000);
    endtask

    logic [63:0] held;

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_addr   = '0;
        for (int k = 0; k < 8192; k++) mem_m[k] = 64'h0;
        rst_n  = 1'b1;
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wem = '0; bus.din = '0;
        bus.sd = 1'b0; bus.ds = 1'b0; bus.ls = 1'b0;

        // reset state
        step("reset0", 1'b1, 1'b0, 1'b0, 13'h0, 8'h00, 64'h0, 3'b000);
        step("reset1", 1'b1, 1'b0, 1'b0, 13'h0, 8'h00, 64'h0, 3'b000);
        check_eq("reset_dout_zero", bus.dout, 64'h0);

        // write then read
        wr("wr_full", 13'h0010, 8'hFF, 64'h0123_4567_89AB_CDEF);
        rd("rd_full", 13'h0010);
        check_eq("wr_rd_value", bus.dout, 64'h0123_4567_89AB_CDEF);

        // byte mask
        wr("wr_mask", 13'h0010, 8'h0F, 64'hFFFF_FFFF_0000_0000);
        check_eq("mask_write_through", bus.dout, 64'h0123_4567_0000_0000);
        rd("rd_mask", 13'h0010);
        check_eq("mask_value", bus.dout, 64'h0123_4567_0000_0000);

        // hold while deselected, then write-through on the held word
        held = bus.dout;
        for (int c = 0; c < 5; c++) begin
            step("hold_sb", 1'b0, 1'b0, 1'($urandom_range(0, 1)), 13'($urandom_range(0, 8191)),
                 8'($urandom_range(0, 255)), {$urandom, $urandom}, 3'b000);
            check_eq("hold_const", bus.dout, held);
        end
        wr("wr_top", 13'h0010, 8'h80, 64'hAA00_0000_0000_0000);
        check_eq("write_through", bus.dout, 64'hAA23_4567_0000_0000);

        // write to another word must not disturb the held read
        wr("wr_other", 13'h0011, 8'hFF, 64'h1111_2222_3333_4444);
        check_eq("other_write_hold", bus.dout, 64'hAA23_4567_0000_0000);

        // unwritten word reads as zero, then a single-byte write
        rd("rd_unwritten", 13'h1FFF);
        check_eq("x2zero", bus.dout, 64'h0);
        wr("wr_last_b0", 13'h1FFF, 8'h01, 64'h0000_0000_0000_0055);
        rd("rd_last", 13'h1FFF);
        check_eq("last_byte0", bus.dout, 64'h0000_0000_0000_0055);

        // wem=0 performs no write
        wr("wr_nomask", 13'h1FFF, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("nomask_hold", bus.dout, 64'h0000_0000_0000_0055);

        // reset priority over a read; write during reset still commits
        wr("wr_m0", 13'h0000, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
        wr("wr_123", 13'h0123, 8'hFF, 64'h5A5A_1234_A5A5_4321);
        rd("rd_123", 13'h0123);
        check_eq("pre_reset", bus.dout, 64'h5A5A_1234_A5A5_4321);
        step("rst_rd", 1'b1, 1'b1, 1'b0, 13'h0456, 8'h00, 64'h0, 3'b000);
        check_eq("reset_vs_read", bus.dout, 64'hDEAD_BEEF_CAFE_F00D);
        rd("rd_123b", 13'h0123);
        check_eq("post_reset_intact", bus.dout, 64'h5A5A_1234_A5A5_4321);
        step("rst_wr", 1'b1, 1'b1, 1'b1, 13'h0456, 8'hFF, 64'h0BAD_F00D_0000_0456, 3'b000);
        rd("rd_456", 13'h0456);
        check_eq("reset_write_commits", bus.dout, 64'h0BAD_F00D_0000_0456);

        // random traffic with power pins toggling; small address window for reuse
        for (int c = 0; c < 1000; c++) begin
            step("rand", 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 13'($urandom_range(0, 31)),
                 8'($urandom_range(0, 255)), {$urandom, $urandom}, 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/itcm_ram_8kx64.md
Name: itcm_ram_8kx64

Overview:
- Single-port synchronous SRAM model backing the E203 instruction TCM: 8192 words x 64 bits, byte-write-masked.
- Sits behind the ITCM controller. One access per cycle: read or write.
- Read data is driven from a registered read address, so read latency is 1 cycle.
- Power-control pins (sd/ds/ls) exist for drop-in compatibility with a hard macro.

Parameters:
- DP, 8192, depth in words.
- DW, 64, data width in bits.
- MW, 8, write-mask width; one bit per byte, DW/MW = 8 bits per lane.
- AW, 13, address width, log2(DP).
- FORCE_X2ZERO, 1, when 1 every unknown (X) bit on dout is driven as 0.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst_n  in  1  Reset, synchronous, active-high. The _n suffix is historical only; the level 1 resets.
- sd  in  1  Shutdown request; no function in the base build.
- ds  in  1  Deep-sleep request; no function in the base build.
- ls  in  1  Light-sleep request; no function in the base build.
- cs  in  1  Chip select; access occurs only when 1.
- we  in  1  1 = write, 0 = read (qualified by cs).
- addr  in  AW  Word address.
- wem  in  MW  Byte write enables; bit i covers din[8i+7:8i].
- din  in  DW  Write data.
- dout  out  DW  Read data.

Behaviour:
- Storage: mem[0..DP-1] of DW bits. Not cleared by reset. Contents start unknown.
- Write, at an edge with cs=1 and we=1: for each i with wem[i]=1, mem[addr] byte i <= din byte i. Bytes with wem[i]=0 are unchanged. wem=0 performs no write.
- Read, at an edge with cs=1 and we=0: register addr into addr_r.
- dout is combinational from mem[addr_r]. It changes only:
  - after a read edge (addr_r updated), or
  - after a write edge that modifies the word at addr_r; dout shows the new bytes in the cycle after that write.
- Read latency: addr presented at edge N gives data valid on dout after edge N, stable until the next read or a write to that word.
- cs=0: no state change; addr_r and dout hold.
- Writes never update addr_r.
- Reset (rst_n=1 at an edge): addr_r <= 0, so dout = mem[0] from the next cycle.
  - Reset has priority over a simultaneous read.
  - A write in the reset cycle still commits to mem.
- Reset mid-operation: a read in the reset cycle is discarded and addr_r = 0.
- X forcing: with FORCE_X2ZERO=1, every X/Z bit of mem[addr_r] is presented as 0. Before any write, dout = 64'h0.
- sd/ds/ls have no effect on storage or dout unless the optional feature is compiled in.
- addr covers the full depth; no out-of-range handling is needed.

Optional Feature:
- Macro ITCM_RAM_PWR_CTRL_EN.
- Defined:
  - Effective chip select = cs & ~sd & ~ds & ~ls; no reads or writes while any power pin is 1.
  - While sd=1, dout = 0 and mem contents become unknown (all words are X-invalidated; they read as 0 when FORCE_X2ZERO=1).
  - ds and ls retain contents; dout holds.
- Undefined: the power pins are ignored entirely, as in Behaviour.

Decomposition:
- Package itcm_ram_pkg holds:
  - ITCM_DP, ITCM_DW, ITCM_MW, ITCM_AW;
  - typedefs itcm_addr_t (13b), itcm_data_t (64b), itcm_wem_t (8b).
- One sub-module, itcm_ram_core: generic parameterised single-port RAM with byte mask, registered read address and the X2ZERO output stage.
- The top level adds the reset of addr_r and the power-pin handling.

Test Plan:
- Write then read: cs=1, we=1, addr=0x0010, wem=8'hFF, din=64'h0123_4567_89AB_CDEF; next cycle cs=1, we=0, addr=0x0010 -> dout=64'h0123_4567_89AB_CDEF one cycle later.
- Byte mask: after the above, write addr=0x0010, wem=8'h0F, din=64'hFFFF_FFFF_0000_0000, then read -> dout=64'h0123_4567_0000_0000.
- Hold and write-through:
  - read 0x0010, then cs=0 with random addr for 5 cycles -> dout unchanged;
  - then write 0x0010, wem=8'h80, din top byte 0xAA -> dout=64'hAA23_4567_0000_0000 next cycle.
- Unwritten / X2ZERO: read addr=0x1FFF (never written) -> dout=64'h0. Also write 0x1FFF with wem=8'h01, din=64'h55 -> read gives 64'h0000_0000_0000_0055.
- Reset:
  - write mem[0]=64'hDEAD_BEEF_CAFE_F00D and read 0x0123;
  - assert rst_n=1 for 1 cycle together with a read of 0x0456 -> dout=64'hDEAD_BEEF_CAFE_F00D;
  - mem[0x0123] is still intact on a later read.
- Power pins ignored (feature off): toggle sd/ds/ls randomly during 1000 random cs/we/addr/wem/din cycles -> dout matches a behavioural model that ignores them.
